// File: rtl/bus_dest_regs_if.sv
// Bus-side signal bundle for bus_dest_regs: destination command inputs,
// the architectural register outputs and the memory-write handshake.
// The slave modport is the register block; the master modport is whoever
// drives the destination select and enables and answers mem_wr_req.
interface bus_dest_regs_if #(
  parameter int W = 16
);
  logic [2:0]   dest_sel;
  logic         load_en;
  logic         inc_en;
  logic         clr_en;
  logic [W-1:0] bus_in;
  logic         mem_ack;

  logic [W-1:0] AR;
  logic [W-1:0] PC;
  logic [W-1:0] DR;
  logic [W-1:0] AC;
  logic [W-1:0] IR;
  logic [W-1:0] TR;

  logic [W-1:0] mem_wr_addr;
  logic [W-1:0] mem_wr_data;
  logic         mem_wr_req;
  logic         busy;
  logic         cmd_drop;
  logic         mem_timeout;

  modport slave (
    input  dest_sel, load_en, inc_en, clr_en, bus_in, mem_ack,
    output AR, PC, DR, AC, IR, TR,
    output mem_wr_addr, mem_wr_data, mem_wr_req, busy, cmd_drop, mem_timeout
  );

  modport master (
    output dest_sel, load_en, inc_en, clr_en, bus_in, mem_ack,
    input  AR, PC, DR, AC, IR, TR,
    input  mem_wr_addr, mem_wr_data, mem_wr_req, busy, cmd_drop, mem_timeout
  );
endinterface

// File: rtl/bus_dest_regs.sv
// Destination end of the common bus. A 3-bit destination select picks one
// of AR/PC/DR/AC/IR/TR for clear/load/increment (clr > load > inc, IR does
// not increment), or 111 for a memory write M[AR] <= bus carried out with a
// req/ack handshake. While a write is outstanding every command is dropped
// and reported with a one-cycle cmd_drop pulse.
// Optional: define MEM_WR_TIMEOUT_EN to abort a write after TIMEOUT_CYC
// cycles without mem_ack and set the sticky mem_timeout flag.
module bus_dest_regs #(
  parameter int W           = 16,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  bus_dest_regs_if.slave bif
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [2:0] D_AR  = 3'd1;
  localparam logic [2:0] D_PC  = 3'd2;
  localparam logic [2:0] D_DR  = 3'd3;
  localparam logic [2:0] D_AC  = 3'd4;
  localparam logic [2:0] D_IR  = 3'd5;
  localparam logic [2:0] D_TR  = 3'd6;
  localparam logic [2:0] D_MEM = 3'd7;

  state_t         state_q, state_d;
  logic [W-1:0]   ar_q, ar_d, pc_q, pc_d, dr_q, dr_d;
  logic [W-1:0]   ac_q, ac_d, ir_q, ir_d, tr_q, tr_d;
  logic [W-1:0]   addr_q, addr_d, data_q, data_d;
  logic           drop_q, drop_d;
  logic           cmd;

`ifdef MEM_WR_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`endif

  // Register update rule: clear wins over load, load over increment.
  function automatic logic [W-1:0] reg_next(
    input logic [W-1:0] cur,
    input logic [W-1:0] bus,
    input logic         ld,
    input logic         inc,
    input logic         clr,
    input logic         inc_ok
  );
    logic [W-1:0] nxt;
    nxt = cur;
    if (clr)
      nxt = '0;
    else if (ld)
      nxt = bus;
    else if (inc && inc_ok)
      nxt = cur + 1'b1;
    return nxt;
  endfunction

  // Decode the command, sequence the memory write and compute next state.
  always_comb begin
    state_d = state_q;
    ar_d    = ar_q;
    pc_d    = pc_q;
    dr_d    = dr_q;
    ac_d    = ac_q;
    ir_d    = ir_q;
    tr_d    = tr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    drop_d  = 1'b0;
`ifdef MEM_WR_TIMEOUT_EN
    cnt_d   = '0;
    tmo_d   = tmo_q;
`endif
    cmd = (bif.load_en || bif.inc_en || bif.clr_en) && (bif.dest_sel != 3'd0);

    if (state_q == S_IDLE) begin
      if (cmd) begin
        unique case (bif.dest_sel)
          D_AR: ar_d = reg_next(ar_q, bif.bus_in, bif.load_en, bif.inc_en, bif.clr_en, 1'b1);
          D_PC: pc_d = reg_next(pc_q, bif.bus_in, bif.load_en, bif.inc_en, bif.clr_en, 1'b1);
          D_DR: dr_d = reg_next(dr_q, bif.bus_in, bif.load_en, bif.inc_en, bif.clr_en, 1'b1);
          D_AC: ac_d = reg_next(ac_q, bif.bus_in, bif.load_en, bif.inc_en, bif.clr_en, 1'b1);
          D_IR: ir_d = reg_next(ir_q, bif.bus_in, bif.load_en, bif.inc_en, bif.clr_en, 1'b0);
          D_TR: tr_d = reg_next(tr_q, bif.bus_in, bif.load_en, bif.inc_en, bif.clr_en, 1'b1);
          D_MEM: begin
            // Only load starts a write; inc/clr on memory do nothing.
            if (bif.load_en) begin
              addr_d  = ar_q;
              data_d  = bif.bus_in;
              state_d = S_WAIT;
            end
          end
          default: ;
        endcase
      end
    end else begin
      // Everything arriving during a write, including the ack cycle, is dropped.
      drop_d = cmd;
      if (bif.mem_ack)
        state_d = S_IDLE;
`ifdef MEM_WR_TIMEOUT_EN
      else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
        state_d = S_IDLE;
        tmo_d   = 1'b1;
      end else
        cnt_d = cnt_q + 1'b1;
`endif
    end
  end

  // State, architectural and write-latch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ar_q    <= '0;
      pc_q    <= '0;
      dr_q    <= '0;
      ac_q    <= '0;
      ir_q    <= '0;
      tr_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ar_q    <= ar_d;
      pc_q    <= pc_d;
      dr_q    <= dr_d;
      ac_q    <= ac_d;
      ir_q    <= ir_d;
      tr_q    <= tr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

`ifdef MEM_WR_TIMEOUT_EN
  // Wait-cycle counter and sticky abort flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign bif.mem_timeout = tmo_q;
`else
  assign bif.mem_timeout = 1'b0;
`endif

  assign bif.AR          = ar_q;
  assign bif.PC          = pc_q;
  assign bif.DR          = dr_q;
  assign bif.AC          = ac_q;
  assign bif.IR          = ir_q;
  assign bif.TR          = tr_q;
  assign bif.mem_wr_addr = addr_q;
  assign bif.mem_wr_data = data_q;
  assign bif.mem_wr_req  = (state_q == S_WAIT);
  assign bif.busy        = (state_q == S_WAIT);
  assign bif.cmd_drop    = drop_q;

endmodule
